// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
//   Asynchronous serial receiver (8N1 by default) that deserialises one byte
//   per frame from a single rx line. o_data feeds the data input of the
//   downstream 8-bit enable-loaded register and o_valid drives its enable.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   -> a PARITY state between DATA and STOP samples a 9th bit
//                  (even parity); a mismatch pulses o_parity_err with the
//                  stop-bit result and suppresses o_valid.
//     undefined -> plain 8N1, o_parity_err tied low.
//
//   Parameters
//     CLKS_PER_BIT  i_clk cycles per serial bit (>= 4)
//
//   Ports
//     i_clk         rising-edge clock
//     i_rst_n       asynchronous active-low reset
//     i_rx          serial line, idle high, asynchronous to i_clk
//     o_data        last correctly received byte
//     o_valid       one-cycle pulse, o_data updated this cycle
//     o_frame_err   one-cycle pulse, stop bit sampled low
//     o_parity_err  one-cycle pulse, parity mismatch
//     o_busy        high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY  = 3'd3,
`endif
    S_STOP    = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  // Stage p0/p1: two-flop synchroniser, preset to the idle (high) level
  logic rx_sync_p0, rx_sync_p1;
  logic rx_s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= i_rx;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign rx_s = rx_sync_p1;

  // Receiver state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_d;
  logic             valid_d, ferr_d, perr_d;
  logic             cnt_last, cnt_mid;
  logic [CNT_W-1:0] cnt_inc;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             par_bad;
  logic             perr_q;
`endif

  assign cnt_last = (cnt_q == CNT_LAST);
  assign cnt_mid  = (cnt_q == CNT_MID);
  assign cnt_inc  = cnt_last ? '0 : cnt_q + CNT_W'(1);
`ifdef UART_RX_PARITY_EN
  // Even parity: the nine received bits must XOR to zero
  assign par_bad  = ^{shift_q, par_q};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = o_data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        // Re-check the line half a bit in; a short low pulse is a glitch
        if (cnt_mid) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DATA: begin
        cnt_d = cnt_inc;
        if (cnt_last) begin
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        cnt_d = cnt_inc;
        if (cnt_last) begin
          par_d   = rx_s;
          state_d = S_STOP;
        end
      end
`endif

      S_STOP: begin
        cnt_d = cnt_inc;
        if (cnt_last) begin
`ifdef UART_RX_PARITY_EN
          perr_d = par_bad;
          if (rx_s) begin
            valid_d = !par_bad;
            if (!par_bad) begin
              data_d = shift_q;
            end
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_RECOVER;
          end
`else
          if (rx_s) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_RECOVER;
          end
`endif
        end
      end

      S_RECOVER: begin
        // Hold here through a break so it reports a single frame error
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Stage p2: registered FSM state and output pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      o_data      <= data_d;
      o_valid     <= valid_d;
      o_frame_err <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q      <= perr_d;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
    par_q   <= par_d;
`endif
  end

`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_byte
//   Directed and randomized frames for uart_rx_byte with CLKS_PER_BIT = 4.
//   A frame-level model (queue of expected bytes, expected error counts) is
//   compared against what a negedge monitor collects from the outputs.
// -----------------------------------------------------------------------------
module tb_uart_rx_byte;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx         (rx),
    .o_data       (data),
    .o_valid      (valid),
    .o_frame_err  (frame_err),
    .o_parity_err (parity_err),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observed side
  logic [7:0] got_q[$];
  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_perr  = 0;
  int         n_both  = 0;
  int         n_wide  = 0;
  int         n_dchg  = 0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;

  // Expected side
  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  int         exp_perr = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        got_q.push_back(data);
        n_valid++;
      end
      if (frame_err)  n_ferr++;
      if (parity_err) n_perr++;
      if (valid && frame_err) n_both++;
      if ((valid && prev_valid) || (frame_err && prev_ferr)) n_wide++;
      if (!valid && data !== prev_data) n_dchg++;
    end
    prev_data  = data;
    prev_valid = valid;
    prev_ferr  = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    cycles(CPB);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    cycles(n * CPB);
  endtask

`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ par_flip);
`endif
    send_bit(stop);
  endtask

  logic [7:0] rb;
  logic       bad_stop;
  int         gap;
  int         v0, f0;

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    cycles(3);
    check("rst_data",  {24'h0, data}, 32'h00);
    check("rst_valid", {31'h0, valid}, 0);
    check("rst_ferr",  {31'h0, frame_err}, 0);
    check("rst_perr",  {31'h0, parity_err}, 0);
    check("rst_busy",  {31'h0, busy}, 0);
    rst_n = 1'b1;
    cycles(20);
    check("idle_busy",  {31'h0, busy}, 0);
    check("idle_valid", n_valid, 0);

    // Single frame 0xA5
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    idle_bits(2);
    check("a5_count", n_valid, 1);
    check("a5_data",  {24'h0, data}, 32'hA5);
    check("a5_ferr",  n_ferr, 0);

    // Back-to-back 0x00 then 0xFF, no idle gap
    send_frame(8'h00, 1'b1);
    exp_q.push_back(8'h00);
    send_frame(8'hFF, 1'b1);
    exp_q.push_back(8'hFF);
    idle_bits(2);
    check("b2b_count", n_valid, 3);
    check("b2b_first", {24'h0, got_q[1]}, 32'h00);
    check("b2b_data",  {24'h0, data}, 32'hFF);

    // Bad stop bit followed by a held-low line
    send_frame(8'h3C, 1'b0);
    exp_ferr++;
    rx = 1'b0;
    cycles(40);
    check("brk_busy",  {31'h0, busy}, 1);
    check("brk_ferr",  n_ferr, 1);
    check("brk_data",  {24'h0, data}, 32'hFF);
    check("brk_valid", n_valid, 3);
    rx = 1'b1;
    cycles(5);
    check("brk_release_busy", {31'h0, busy}, 0);
    check("brk_ferr_once", n_ferr, 1);

    // One-cycle low glitch
    rx = 1'b0;
    cycles(1);
    rx = 1'b1;
    cycles(6);
    check("glitch_busy",  {31'h0, busy}, 0);
    check("glitch_valid", n_valid, 3);
    check("glitch_ferr",  n_ferr, 1);

    // Reset in the middle of data bit 4, then a clean frame 0x81
    rb = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(rb[i]);
    rx = rb[4];
    cycles(2);
    rst_n = 1'b0;
    cycles(2);
    check("mid_rst_data", {24'h0, data}, 32'h00);
    check("mid_rst_busy", {31'h0, busy}, 0);
    check("mid_rst_valid", {31'h0, valid}, 0);
    rx = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    idle_bits(2);
    check("mid_rst_nopulse", n_valid, 3);
    send_frame(8'h81, 1'b1);
    exp_q.push_back(8'h81);
    idle_bits(2);
    check("after_rst_data",  {24'h0, data}, 32'h81);
    check("after_rst_count", n_valid, 4);

`ifdef UART_RX_PARITY_EN
    // Parity: correct bit -> byte accepted; wrong bit -> parity error only
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    exp_q.push_back(8'h07);
    idle_bits(2);
    check("par_ok_data", {24'h0, data}, 32'h07);
    check("par_ok_perr", n_perr, 0);
    par_flip = 1'b1;
    send_frame(8'h70, 1'b1);
    exp_perr++;
    idle_bits(2);
    check("par_bad_data", {24'h0, data}, 32'h07);
    check("par_bad_perr", n_perr, 1);
    check("par_bad_ferr", n_ferr, exp_ferr);
    par_flip = 1'b0;
`endif

    // Randomized frames with random stop-bit faults and idle gaps
    for (int k = 0; k < 24; k++) begin
      rb       = 8'($urandom_range(0, 255));
      bad_stop = ($urandom_range(0, 4) == 0);
`ifdef UART_RX_PARITY_EN
      par_flip = ($urandom_range(0, 5) == 0);
`endif
      v0 = n_valid;
      f0 = n_ferr;
      send_frame(rb, !bad_stop);
`ifdef UART_RX_PARITY_EN
      if (par_flip) exp_perr++;
      if (!bad_stop && !par_flip) exp_q.push_back(rb);
`else
      if (!bad_stop) exp_q.push_back(rb);
`endif
      if (bad_stop) exp_ferr++;
      gap = bad_stop ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2);
      idle_bits(gap);
    end
    idle_bits(3);

    check("rand_count", n_valid, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("byte_%0d", i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
    check("ferr_total", n_ferr, exp_ferr);
    check("perr_total", n_perr, exp_perr);
    check("valid_ferr_overlap", n_both, 0);
    check("pulse_width", n_wide, 0);
    check("data_only_on_valid", n_dchg, 0);
    check("final_busy", {31'h0, busy}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
